// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ byte streams.
// A grant lasts until the owner's last byte or MAX_BURST bytes, whichever comes first.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int C_DATA_BITS = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESET,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*C_DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             Full,
    output logic [C_DATA_BITS-1:0]           TX_data,
    output logic                             wr_uart_en,
    output logic                             grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);

    localparam logic [IDW:0]   NREQ    = (IDW + 1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  BCAP    = CW'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  burst_cnt;

    logic [C_DATA_BITS-1:0] data_arr [NUM_REQ];

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW-1:0]       pos;
    logic [IDW:0]         sum;
    logic [IDW-1:0]       sel_id;
    logic                 sel_found;
    logic                 hs;
    logic                 release_now;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
        assign data_arr[i] = req_data[i*C_DATA_BITS +: C_DATA_BITS];
    end

    // Rotate so rr_ptr lands at bit 0, find the lowest set bit, then rotate back.
    always_comb begin
        dbl       = {req_valid, req_valid} >> rr_ptr;
        rot       = dbl[NUM_REQ-1:0];
        pos       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = IDW'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, pos};
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        sel_id    = sum[IDW-1:0];
        sel_found = |req_valid;
    end

    always_comb begin
        req_ready = '0;
        if (state == GRANT && !Full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign hs          = (state == GRANT) && !Full && req_valid[grant_id];
    assign release_now = hs && (req_last[grant_id] || burst_cnt == BCAP);
    assign wr_uart_en  = hs;
    assign TX_data     = hs ? data_arr[grant_id] : '0;
    assign grant_valid = (state == GRANT);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id  <= sel_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                        rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    end else if (hs) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed cycle-table bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic        Full = 1'b0;
    logic [7:0]  TX_data;
    logic        wr_uart_en;
    logic        grant_valid;
    logic [1:0]  grant_id;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .C_DATA_BITS(8),
        .MAX_BURST(4)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESET(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .Full(Full),
        .TX_data(TX_data),
        .wr_uart_en(wr_uart_en),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  rdy;
        logic        wr;
        logic [7:0]  tx;
        logic        gv;
        logic [1:0]  gid;
        logic        chk;
        int          crr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(input logic r, input logic [3:0] v,
                               input logic [3:0] l, input logic f,
                               input logic [31:0] d, input logic [3:0] rdy,
                               input logic wr, input logic [7:0] tx,
                               input logic gv, input logic [1:0] gid,
                               input logic chk, input int crr);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.f = f; t.d = d;
        t.rdy = rdy; t.wr = wr; t.tx = tx; t.gv = gv; t.gid = gid;
        t.chk = chk; t.crr = crr;
        return t;
    endfunction

    function automatic vec_t I(input logic r, input logic [3:0] v,
                               input logic [31:0] d, input int crr);
        return V(r, v, 4'b0, 1'b0, d, 4'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, crr);
    endfunction

    function automatic vec_t G(input logic [3:0] v, input logic [3:0] l,
                               input logic f, input logic [31:0] d,
                               input logic [3:0] rdy, input logic wr,
                               input logic [7:0] tx, input logic [1:0] gid);
        return V(1'b0, v, l, f, d, rdy, wr, tx, 1'b1, gid, 1'b1, -1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] exp;
        logic        found;

        // single requester, 3 bytes
        tbl.push_back(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(I(1, 4'b0000, 32'h0, -1));
        tbl.push_back(I(0, 4'b0010, 32'h0000_4100, -1));
        tbl.push_back(G(4'b0010, 4'b0000, 0, 32'h0000_4100, 4'b0010, 1, 8'h41, 1));
        tbl.push_back(G(4'b0010, 4'b0000, 0, 32'h0000_4200, 4'b0010, 1, 8'h42, 1));
        tbl.push_back(G(4'b0010, 4'b0010, 0, 32'h0000_4300, 4'b0010, 1, 8'h43, 1));
        tbl.push_back(I(0, 4'b0000, 32'h0, 2));
        // contention req0 vs req2 from reset
        tbl.push_back(I(1, 4'b0000, 32'h0, -1));
        tbl.push_back(I(0, 4'b0101, 32'h0020_0010, 0));
        tbl.push_back(G(4'b0101, 4'b0000, 0, 32'h0020_0010, 4'b0001, 1, 8'h10, 0));
        tbl.push_back(G(4'b0101, 4'b0001, 0, 32'h0020_0011, 4'b0001, 1, 8'h11, 0));
        tbl.push_back(I(0, 4'b0100, 32'h0020_0000, 1));
        tbl.push_back(G(4'b0100, 4'b0000, 0, 32'h0020_0000, 4'b0100, 1, 8'h20, 2));
        tbl.push_back(G(4'b0100, 4'b0100, 0, 32'h0021_0000, 4'b0100, 1, 8'h21, 2));
        tbl.push_back(I(0, 4'b0000, 32'h0, 3));
        // backpressure on req3
        tbl.push_back(I(0, 4'b1000, 32'h3000_0000, -1));
        tbl.push_back(G(4'b1000, 4'b0000, 0, 32'h3000_0000, 4'b1000, 1, 8'h30, 3));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(G(4'b1000, 4'b0000, 1, 32'h3100_0000, 4'b0000, 0, 8'h00, 3));
        end
        tbl.push_back(G(4'b1000, 4'b0000, 0, 32'h3100_0000, 4'b1000, 1, 8'h31, 3));
        tbl.push_back(G(4'b1000, 4'b1000, 0, 32'h3200_0000, 4'b1000, 1, 8'h32, 3));
        tbl.push_back(I(0, 4'b0000, 32'h0, 0));
        // burst cap of 4 with req1 waiting
        tbl.push_back(I(0, 4'b0011, 32'h0000_6050, -1));
        tbl.push_back(G(4'b0011, 4'b0000, 0, 32'h0000_6050, 4'b0001, 1, 8'h50, 0));
        tbl.push_back(G(4'b0011, 4'b0000, 0, 32'h0000_6051, 4'b0001, 1, 8'h51, 0));
        tbl.push_back(G(4'b0011, 4'b0000, 0, 32'h0000_6052, 4'b0001, 1, 8'h52, 0));
        tbl.push_back(G(4'b0011, 4'b0000, 0, 32'h0000_6053, 4'b0001, 1, 8'h53, 0));
        tbl.push_back(I(0, 4'b0011, 32'h0000_6054, 1));
        tbl.push_back(G(4'b0011, 4'b0000, 0, 32'h0000_6054, 4'b0010, 1, 8'h60, 1));
        tbl.push_back(G(4'b0011, 4'b0010, 0, 32'h0000_6154, 4'b0010, 1, 8'h61, 1));
        tbl.push_back(I(0, 4'b0001, 32'h0000_0054, 2));
        tbl.push_back(G(4'b0001, 4'b0000, 0, 32'h0000_0054, 4'b0001, 1, 8'h54, 0));
        tbl.push_back(G(4'b0001, 4'b0001, 0, 32'h0000_0055, 4'b0001, 1, 8'h55, 0));
        tbl.push_back(I(0, 4'b0000, 32'h0, 1));
        // reset mid-message
        tbl.push_back(I(0, 4'b0100, 32'h0070_0000, -1));
        tbl.push_back(G(4'b0100, 4'b0000, 0, 32'h0070_0000, 4'b0100, 1, 8'h70, 2));
        tbl.push_back(G(4'b0100, 4'b0000, 0, 32'h0071_0000, 4'b0100, 1, 8'h71, 2));
        tbl.push_back(V(1, 4'b0100, 0, 0, 32'h0072_0000, 0, 0, 0, 0, 0, 0, -1));
        tbl.push_back(I(0, 4'b0101, 32'h0072_0080, 0));
        tbl.push_back(G(4'b0101, 4'b0001, 0, 32'h0072_0080, 4'b0001, 1, 8'h80, 0));
        tbl.push_back(I(0, 4'b0000, 32'h0, 1));
        // round-robin wrap, 1-byte messages from all four
        tbl.push_back(I(1, 4'b0000, 32'h0, -1));
        for (int k = 0; k < 6; k++) begin
            logic [1:0] id;
            id = 2'(k % 4);
            tbl.push_back(I(0, 4'b1111, 32'hA3A2_A1A0, (k == 0) ? 0 : int'(id)));
            tbl.push_back(G(4'b1111, 4'b1111, 0, 32'hA3A2_A1A0, 4'b0001 << id,
                            1, 8'hA0 + 8'(id), id));
        end
        tbl.push_back(I(0, 4'b0000, 32'h0, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst       = tbl[i].r;
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            Full      = tbl[i].f;
            req_data  = tbl[i].d;
            #1;
            if (tbl[i].chk) begin
                got = {req_ready, wr_uart_en, TX_data, grant_valid,
                       tbl[i].gv ? grant_id : 2'd0};
                exp = {tbl[i].rdy, tbl[i].wr, tbl[i].tx, tbl[i].gv, tbl[i].gid};
                chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
            end
            if (tbl[i].crr >= 0) begin
                chk($sformatf("vec%0d_rr", i), 32'(dut.rr_ptr), 32'(tbl[i].crr));
            end
        end

        // grant is held while the owner drops valid; others are locked out
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_last = '0; Full = 1'b0; req_data = '0;
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0010; req_data = 32'h0000_9000;
        @(negedge clk);
        #1;
        chk("hold_first", {grant_valid, grant_id, wr_uart_en, TX_data},
            {1'b1, 2'd1, 1'b1, 8'h90});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_data = 32'h0000_00EE;
            #1;
            chk($sformatf("hold_%0d", k),
                {req_ready, grant_valid, grant_id, wr_uart_en, TX_data},
                {4'b0010, 1'b1, 2'd1, 1'b0, 8'h00});
        end
        @(negedge clk);
        req_valid = 4'b0011; req_last = 4'b0010; req_data = 32'h0000_91B0;
        #1;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (wr_uart_en) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("resume_seen", 32'(found), 32'd1);
        chk("resume_data", 32'(TX_data), 32'h91);
        @(negedge clk);
        req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_00B0;
        #1;
        chk("after_release", {grant_valid, wr_uart_en}, 2'b00);
        chk("after_release_rr", 32'(dut.rr_ptr), 32'd2);
        @(negedge clk);
        #1;
        chk("next_owner", {grant_valid, grant_id, wr_uart_en, TX_data},
            {1'b1, 2'd0, 1'b1, 8'hB0});
        @(negedge clk);
        req_valid = '0; req_last = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART TX FIFO write port (TX_data / wr_uart_en / Full) among NUM_REQ byte-stream requesters, e.g. the AXI-Lite slave write path, a debug console and a status reporter.
- A grant is held for a whole message, ending on the requester's last flag, or until MAX_BURST bytes have been sent, so multi-byte messages are not interleaved on the line.
- Sits between the requesters and the UART instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- C_DATA_BITS, 8, UART character width.
- MAX_BURST, 16, maximum bytes per grant before forced release (≥1).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*C_DATA_BITS  per-requester byte; requester i uses bits [i*C_DATA_BITS +: C_DATA_BITS].
- req_last  in  NUM_REQ  per-requester marker: current byte ends the message.
- req_ready  out  NUM_REQ  per-requester byte accepted this cycle.
- Full  in  1  UART TX FIFO full.
- TX_data  out  C_DATA_BITS  byte to the UART TX FIFO.
- wr_uart_en  out  1  UART TX FIFO write strobe.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  $clog2(NUM_REQ)  index of the owner.

Behaviour:
- Reset is synchronous and active-high, and takes effect on any cycle, including mid-message. On reset:
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - grant_valid=0, grant_id=0.
  - req_ready=0, wr_uart_en=0, TX_data=0.
  - A partially sent message is abandoned; bytes already written stay in the FIFO.
- State IDLE:
  - If any req_valid is high, select the first set bit searching from rr_ptr upward with wrap-around.
  - Register grant_id=selected, grant_valid=1, burst_cnt=0, go to GRANT.
  - Arbitration costs exactly one cycle: no byte is accepted in IDLE.
- State GRANT, with g=grant_id:
  - req_ready[g] = !Full. All other req_ready bits are 0. This is combinational.
  - Handshake: a byte moves when req_valid[g] && req_ready[g]. In that same cycle wr_uart_en=1 and TX_data=req_data[g], both combinational with no added latency.
  - In every cycle without a handshake, wr_uart_en=0 and TX_data=0.
  - On a handshake, burst_cnt increments.
- Release from GRANT:
  - Release happens on the handshake cycle where req_last[g]=1, or where burst_cnt==MAX_BURST-1.
  - On release: state=IDLE, grant_valid=0, rr_ptr=(g+1) mod NUM_REQ, burst_cnt=0.
  - A release due to the burst cap does not end the message. The requester re-arbitrates for the remainder of the message.
- Requester behaviour during GRANT:
  - If req_valid[g] deasserts, the grant is held with no timeout. Requesters must keep valid asserted through the message.
  - If the FIFO is full (Full=1), req_ready[g]=0 and the grant is held. There is no data loss and no handshake.
- req_last is ignored when there is no handshake.
- A requester that drops valid while not granted loses nothing, because the arbiter keeps no per-requester state.
- Simultaneous requests are resolved purely by rr_ptr priority. The previous owner becomes lowest priority.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.
- Throughput is at most one byte per cycle within a grant. Each message costs one idle arbitration cycle.

Test Plan:
- Reset then single requester: req1 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, Full=0.
  - Required: grant_id=1 on cycle after valid; wr_uart_en high 3 consecutive cycles with the bytes in order; grant_valid drops; rr_ptr=2.
- Contention: req0 and req2 both valid with 2-byte messages from reset.
  - Required: req0 is served first; one idle cycle; then req2; the two messages are never interleaved in the TX_data sequence.
- Backpressure: Full=1 for 4 cycles mid-message from req3.
  - Required: req_ready[3]=0 and wr_uart_en=0 during those cycles; grant_id stays 3; transfer resumes the cycle Full drops; no byte is duplicated or lost.
- Burst cap: MAX_BURST=4; req0 streams 6 bytes (last on the 6th) while req1 waits.
  - Required: bytes 1-4 from req0; release; req1's message is served; then req0's bytes 5-6.
- Reset mid-message: assert S_AXI_ARESET after 2 of 5 bytes are sent.
  - Required: next cycle grant_valid=0, req_ready=0, wr_uart_en=0, rr_ptr=0; after reset, arbitration restarts from requester 0.
- Round-robin wrap: NUM_REQ=4, all four requesters continuously sending 1-byte messages.
  - Required: grant order 0,1,2,3,0,1 with one byte every 2 cycles.
